// File: rtl/commit_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : commit_monitor                                                  |
// | Purpose  : retirement order numbering, self-jump halt and idle watchdog.   |
// | Option   : COMMIT_MON_WATCHDOG_EN adds the idle counter / TIMED_OUT state. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module commit_monitor #(
    parameter int NRET        = 2,
    parameter int XLEN        = 32,
    parameter int ORDER_W     = 64,
    parameter int HALT_REPEAT = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall_i,
    input  logic [NRET-1:0]           commit_i,
    input  logic [NRET*7-1:0]         opcode_i,
    input  logic [NRET*XLEN-1:0]      pc_rdata_i,
    input  logic [NRET*XLEN-1:0]      pc_wdata_i,
    output logic [NRET*ORDER_W-1:0]   order_o,
    output logic [ORDER_W-1:0]        order_count_o,
    output logic                      halt_o,
    output logic                      timeout_o
);

    localparam logic [1:0]         c_ST_RUN       = 2'd0;
    localparam logic [1:0]         c_ST_HALTED    = 2'd1;
    localparam logic [1:0]         c_ST_TIMED_OUT = 2'd2;
    localparam logic [6:0]         c_OP_JAL       = 7'b1101111;
    localparam logic [3:0]         c_HALT_CNT     = 4'(HALT_REPEAT);
    localparam logic [ORDER_W-1:0] c_ORDER_ONE    = ORDER_W'(1);
    // An out-of-range configuration never retires anything, so misuse is obvious.
    localparam bit c_CFG_LEGAL = (HALT_REPEAT >= 1) && (HALT_REPEAT <= 15) && (TIMEOUT >= 2);

    logic [1:0]         state_q, state_d;
    logic [ORDER_W-1:0] order_count_q, order_count_d;
    logic [3:0]         rep_q, rep_d;
    logic [NRET-1:0]    w_eff;
    logic [NRET-1:0]    w_self_jump;
    logic               w_any_commit;
    logic               w_halt_hit;
    logic               w_idle_expire;

    for (genvar k = 0; k < NRET; k++) begin : g_lane
        assign w_eff[k] = commit_i[k] & ~stall_i & (state_q == c_ST_RUN) & c_CFG_LEGAL;
        assign w_self_jump[k] = w_eff[k]
                             && (opcode_i[7*k +: 7] == c_OP_JAL)
                             && (pc_wdata_i[k*XLEN +: XLEN] == pc_rdata_i[k*XLEN +: XLEN])
                             && (pc_rdata_i[k*XLEN +: XLEN] != '0);
    end

    assign w_any_commit  = |w_eff;
    assign order_count_o = order_count_q;

    always_comb begin : order_lanes
        logic [ORDER_W-1:0] v_next;
        v_next = order_count_q;
        for (int k = 0; k < NRET; k++) begin
            order_o[k*ORDER_W +: ORDER_W] = v_next;
            if (w_eff[k]) begin
                v_next = v_next + c_ORDER_ONE;
            end
        end
    end

    // Walk lanes oldest first; once a lane triggers halt, younger lanes are dropped.
    always_comb begin : retire_walk
        logic [3:0]         v_rep;
        logic [ORDER_W-1:0] v_cnt;
        logic               v_hit;
        v_rep = rep_q;
        v_cnt = order_count_q;
        v_hit = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            if (w_eff[k] && !v_hit) begin
                v_cnt = v_cnt + c_ORDER_ONE;
                v_rep = w_self_jump[k] ? (v_rep + 4'd1) : 4'd0;
                if (v_rep == c_HALT_CNT) begin
                    v_hit = 1'b1;
                end
            end
        end
        rep_d         = v_rep;
        order_count_d = v_cnt;
        w_halt_hit    = v_hit;
    end

`ifdef COMMIT_MON_WATCHDOG_EN
    localparam int c_IDLE_W = $clog2(TIMEOUT + 1);

    logic [c_IDLE_W-1:0] idle_q, idle_d;

    always_comb begin
        idle_d = idle_q;
        if (w_any_commit) begin
            idle_d = '0;
        end else if (idle_q != c_IDLE_W'(TIMEOUT)) begin
            idle_d = idle_q + c_IDLE_W'(1);
        end
    end

    assign w_idle_expire = !w_any_commit && (idle_q == c_IDLE_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_q <= '0;
        end else begin
            idle_q <= idle_d;
        end
    end
`else
    assign w_idle_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Halt wins over a simultaneous timeout; terminal states hold until reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_RUN: begin
                if (w_halt_hit) begin
                    state_d = c_ST_HALTED;
                end else if (w_idle_expire) begin
                    state_d = c_ST_TIMED_OUT;
                end
            end
            c_ST_HALTED:    state_d = c_ST_HALTED;
            c_ST_TIMED_OUT: state_d = c_ST_TIMED_OUT;
            default:        state_d = c_ST_RUN;
        endcase
    end

    always_comb begin
        halt_o = (state_q == c_ST_HALTED);
`ifdef COMMIT_MON_WATCHDOG_EN
        timeout_o = (state_q == c_ST_TIMED_OUT);
`else
        timeout_o = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            order_count_q <= '0;
            rep_q         <= 4'd0;
        end else begin
            order_count_q <= order_count_d;
            rep_q         <= rep_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_commit_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_commit_monitor                                               |
// | Purpose  : directed scoreboard bench for commit_monitor (NRET=2).           |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_commit_monitor;

`ifdef COMMIT_MON_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_ADD = 7'b0110011;

    logic         clk = 1'b0;
    logic         rst;
    logic         stall;
    logic [1:0]   commit;
    logic [13:0]  opcode;
    logic [63:0]  pc_r;
    logic [63:0]  pc_w;
    logic [127:0] order;
    logic [63:0]  order_count;
    logic         halt;
    logic         tout;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    typedef enum int {K_ORD0, K_ORD1, K_CNT, K_HALT, K_TO} kind_t;
    typedef struct {
        kind_t       kind;
        logic [63:0] val;
        string       tag;
    } exp_t;
    exp_t sb[$];

    commit_monitor #(
        .NRET(2), .XLEN(32), .ORDER_W(64), .HALT_REPEAT(2), .TIMEOUT(8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .commit_i      (commit),
        .opcode_i      (opcode),
        .pc_rdata_i    (pc_r),
        .pc_wdata_i    (pc_w),
        .order_o       (order),
        .order_count_o (order_count),
        .halt_o        (halt),
        .timeout_o     (tout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input logic [1:0] c, input logic s,
                         input logic [6:0] op0, input logic [31:0] r0, input logic [31:0] w0,
                         input logic [6:0] op1, input logic [31:0] r1, input logic [31:0] w1);
        commit = c;
        stall  = s;
        opcode = {op1, op0};
        pc_r   = {r1, r0};
        pc_w   = {w1, w0};
    endtask

    task automatic idle();
        lanes(2'b00, 1'b0, OP_ADD, 32'h0, 32'h0, OP_ADD, 32'h0, 32'h0);
    endtask

    task automatic push(input kind_t k, input logic [63:0] v, input string tag);
        exp_t e;
        e.kind = k;
        e.val  = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    function automatic logic [63:0] observed(input kind_t k);
        case (k)
            K_ORD0:  return order[63:0];
            K_ORD1:  return order[127:64];
            K_CNT:   return order_count;
            K_HALT:  return {63'd0, halt};
            default: return {63'd0, tout};
        endcase
    endfunction

    task automatic drain();
        while (sb.size() > 0) begin
            exp_t        e;
            logic [63:0] o;
            e = sb.pop_front();
            o = observed(e.kind);
            total++;
            assert (o === e.val) passed++;
            else begin
                fails++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic status(input logic [63:0] cnt, input logic h, input logic t, input string tag);
        push(K_CNT,  cnt,           {tag, "_count"});
        push(K_HALT, {63'd0, h},    {tag, "_halt"});
        push(K_TO,   {63'd0, t},    {tag, "_timeout"});
        drain();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        lanes(2'b11, 1'b0, OP_ADD, 32'h100, 32'h104, OP_ADD, 32'h104, 32'h108);
        tick();
        tick();
        rst = 1'b0;
        status(64'd0, 1'b0, 1'b0, "reset_discard");

        // Full-width bursts
        for (int i = 0; i < 3; i++) begin
            lanes(2'b11, 1'b0, OP_ADD, 32'h100, 32'h104, OP_ADD, 32'h104, 32'h108);
            #1;
            push(K_ORD0, 64'(2 * i),     "burst_ord0");
            push(K_ORD1, 64'(2 * i + 1), "burst_ord1");
            drain();
            tick();
            push(K_CNT, 64'(2 * i + 2), "burst_count");
            drain();
        end
        status(64'd6, 1'b0, 1'b0, "burst_total");

        // Stall masks lane 1
        lanes(2'b10, 1'b1, OP_ADD, 32'h0, 32'h0, OP_ADD, 32'h200, 32'h204);
        for (int i = 0; i < 2; i++) begin
            tick();
            push(K_CNT, 64'd6, "stalled_count");
            drain();
        end
        stall = 1'b0;
        #1;
        push(K_ORD1, 64'd6, "unstall_ord1");
        drain();
        tick();
        status(64'd7, 1'b0, 1'b0, "unstall");

        // JAL to itself at pc 0 is not a self-jump
        for (int i = 0; i < 3; i++) begin
            lanes(2'b01, 1'b0, OP_JAL, 32'h0, 32'h0, OP_ADD, 32'h0, 32'h0);
            tick();
            status(64'(8 + i), 1'b0, 1'b0, "zero_pc_jal");
        end

        // Self-jump, ADD, self-jump, idle, self-jump
        lanes(2'b01, 1'b0, OP_JAL, 32'h200, 32'h200, OP_ADD, 32'h0, 32'h0);
        tick();
        status(64'd11, 1'b0, 1'b0, "sj_first");
        lanes(2'b01, 1'b0, OP_ADD, 32'h200, 32'h204, OP_ADD, 32'h0, 32'h0);
        tick();
        status(64'd12, 1'b0, 1'b0, "sj_broken_by_add");
        lanes(2'b01, 1'b0, OP_JAL, 32'h200, 32'h200, OP_ADD, 32'h0, 32'h0);
        tick();
        status(64'd13, 1'b0, 1'b0, "sj_restart");
        idle();
        tick();
        status(64'd13, 1'b0, 1'b0, "sj_idle_gap");
        lanes(2'b01, 1'b0, OP_JAL, 32'h200, 32'h200, OP_ADD, 32'h0, 32'h0);
        tick();
        status(64'd14, 1'b1, 1'b0, "sj_halt");
        lanes(2'b11, 1'b0, OP_ADD, 32'h300, 32'h304, OP_ADD, 32'h304, 32'h308);
        tick();
        tick();
        status(64'd14, 1'b1, 1'b0, "halt_frozen");

        do_reset();
        status(64'd0, 1'b0, 1'b0, "reset_from_halt");

        // Both lanes self-jump in one cycle
        lanes(2'b11, 1'b0, OP_JAL, 32'h60, 32'h60, OP_JAL, 32'h60, 32'h60);
        #1;
        push(K_ORD0, 64'd0, "dual_sj_ord0");
        push(K_ORD1, 64'd1, "dual_sj_ord1");
        drain();
        tick();
        status(64'd2, 1'b1, 1'b0, "dual_sj_halt");
        lanes(2'b11, 1'b0, OP_ADD, 32'h60, 32'h64, OP_ADD, 32'h64, 32'h68);
        tick();
        status(64'd2, 1'b1, 1'b0, "dual_sj_frozen");

        do_reset();
        status(64'd0, 1'b0, 1'b0, "reset_again");

        // Halt on lane 0 drops the younger lane 1 commit
        lanes(2'b01, 1'b0, OP_JAL, 32'h80, 32'h80, OP_ADD, 32'h0, 32'h0);
        tick();
        status(64'd1, 1'b0, 1'b0, "lane0_sj_first");
        lanes(2'b11, 1'b0, OP_JAL, 32'h80, 32'h80, OP_ADD, 32'h84, 32'h88);
        tick();
        status(64'd2, 1'b1, 1'b0, "younger_lane_dropped");

        do_reset();
        status(64'd0, 1'b0, 1'b0, "reset_before_idle");

        // Watchdog boundary: commit on the last idle cycle wins
        idle();
        for (int i = 0; i < 7; i++) begin
            tick();
            push(K_TO, 64'd0, "idle_pre_commit");
            drain();
        end
        lanes(2'b01, 1'b0, OP_ADD, 32'h400, 32'h404, OP_ADD, 32'h0, 32'h0);
        tick();
        status(64'd1, 1'b0, 1'b0, "commit_beats_timeout");
        idle();
        for (int i = 0; i < 7; i++) begin
            tick();
            push(K_TO, 64'd0, "idle_second_run");
            drain();
        end
        tick();
        push(K_TO, {63'd0, WD_EN}, "idle_expiry");
        drain();
        lanes(2'b11, 1'b0, OP_ADD, 32'h400, 32'h404, OP_ADD, 32'h404, 32'h408);
        tick();
        status(WD_EN ? 64'd1 : 64'd3, 1'b0, WD_EN, "after_expiry");

        do_reset();
        status(64'd0, 1'b0, 1'b0, "reset_from_timeout");
        lanes(2'b01, 1'b0, OP_ADD, 32'h500, 32'h504, OP_ADD, 32'h0, 32'h0);
        #1;
        push(K_ORD0, 64'd0, "post_reset_ord0");
        drain();
        tick();
        status(64'd1, 1'b0, 1'b0, "post_reset_commit");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
